// File: rtl/chiplet_types_pkg.sv
// ============================================================================
// chiplet_types_pkg : shared chiplet link types and TX lane manager helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package chiplet_types_pkg;

    localparam int ENC_FLIT_W = 50;

    typedef logic [ENC_FLIT_W-1:0] enc_flit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } phy_tx_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phy_tx_fifo.sv
// ============================================================================
// phy_tx_fifo : count-based flit FIFO, pointers wrap at DEPTH-1 (any depth)
// Rev 1.0
// ============================================================================
`default_nettype none

module phy_tx_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  c_LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == c_DEPTH);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/phy_tx_lane_manager.sv
// ============================================================================
// phy_tx_lane_manager : credit-gated flit serialiser onto the TX lane bus
// Optional lane parity output enabled by PHY_TX_LANE_PARITY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module phy_tx_lane_manager
    import chiplet_types_pkg::*;
#(
    parameter int ENC_W       = ENC_FLIT_W,
    parameter int LANE_W      = 10,
    parameter int DEPTH       = 4,
    parameter int MAX_CREDITS = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               data_ready,
    input  logic [ENC_W-1:0]                   encoded_flit,
    output logic                               buffer_full,
    output logic [LANE_W-1:0]                  lane_data,
    output logic                               lane_valid,
    output logic                               lane_sof,
    output logic                               lane_eof,
    input  logic                               credit_return,
    output logic [$clog2(MAX_CREDITS+1)-1:0]   credits,
`ifdef PHY_TX_LANE_PARITY_EN
    output logic                               lane_par,
`endif
    output logic                               credit_err
);

    localparam int                 NBEATS      = ceil_div(ENC_W, LANE_W);
    localparam int                 PAD_W       = NBEATS * LANE_W;
    localparam int                 BEAT_W      = $clog2(NBEATS);
    localparam int                 CRED_W      = $clog2(MAX_CREDITS + 1);
    localparam int                 CNT_W       = $clog2(DEPTH + 1);
    localparam logic [BEAT_W-1:0]  c_LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [BEAT_W-1:0]  c_PENULT    = BEAT_W'(NBEATS - 2);
    localparam logic [CRED_W-1:0]  c_MAX_CRED  = CRED_W'(MAX_CREDITS);
    localparam logic [CNT_W-1:0]   c_DEPTH     = CNT_W'(DEPTH);

    phy_tx_state_t     r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [PAD_W-1:0]  r_shift;
    logic [LANE_W-1:0] r_lane_data;
    logic              r_lane_valid;
    logic              r_lane_sof;
    logic              r_lane_eof;
    logic [CRED_W-1:0] r_credits;
    logic              r_credit_err;

    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [ENC_W-1:0]  w_head;
    logic [PAD_W-1:0]  w_head_pad;
    logic [LANE_W-1:0] w_next_beat;
    logic              w_push;
    logic              w_can_load;
    logic              w_load;
    logic              w_emit;

    phy_tx_fifo #(
        .WIDTH (ENC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (encoded_flit),
        .pop   (w_load),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_push      = data_ready && !w_full;
    assign buffer_full = (w_count == c_DEPTH);

    // A load happens from IDLE or on the last beat, so back-to-back flits have no bubble.
    assign w_can_load  = !w_empty && (r_credits != '0);
    assign w_load      = w_can_load && ((r_state == IDLE) || (r_beat == c_LAST_BEAT));
    assign w_emit      = w_load || ((r_state == SEND) && (r_beat != c_LAST_BEAT));
    assign w_head_pad  = PAD_W'(w_head);
    assign w_next_beat = w_load ? w_head_pad[LANE_W-1:0] : r_shift[LANE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_shift      <= '0;
            r_lane_data  <= '0;
            r_lane_valid <= 1'b0;
            r_lane_sof   <= 1'b0;
            r_lane_eof   <= 1'b0;
        end else begin
            r_lane_valid <= w_emit;
            r_lane_data  <= w_emit ? w_next_beat : '0;
            r_lane_sof   <= w_load;
            r_lane_eof   <= w_emit && !w_load && (r_beat == c_PENULT);
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= SEND;
                        r_beat  <= '0;
                        r_shift <= w_head_pad >> LANE_W;
                    end
                end
                SEND: begin
                    if (w_load) begin
                        r_beat  <= '0;
                        r_shift <= w_head_pad >> LANE_W;
                    end else if (r_beat == c_LAST_BEAT) begin
                        r_state <= IDLE;
                    end else begin
                        r_beat  <= r_beat + 1'b1;
                        r_shift <= r_shift >> LANE_W;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits    <= c_MAX_CRED;
            r_credit_err <= 1'b0;
        end else if (credit_return && !w_load) begin
            if (r_credits == c_MAX_CRED) begin
                r_credit_err <= 1'b1;
            end else begin
                r_credits <= r_credits + 1'b1;
            end
        end else if (w_load && !credit_return) begin
            r_credits <= r_credits - 1'b1;
        end
    end

`ifdef PHY_TX_LANE_PARITY_EN
    logic r_lane_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane_par <= 1'b0;
        end else begin
            r_lane_par <= w_emit ? ^w_next_beat : 1'b0;
        end
    end

    assign lane_par = r_lane_par;
`endif

    assign lane_data  = r_lane_data;
    assign lane_valid = r_lane_valid;
    assign lane_sof   = r_lane_sof;
    assign lane_eof   = r_lane_eof;
    assign credits    = r_credits;
    assign credit_err = r_credit_err;

endmodule

`default_nettype wire

// File: tb/tb_phy_tx_lane_manager.sv
// Self-checking bench for phy_tx_lane_manager: directed scenarios then random traffic,
// compared every cycle against a queue-based model of flits and pending beats.
`default_nettype none
`timescale 1ns/1ps

module tb_phy_tx_lane_manager;

    localparam int ENC_W       = 50;
    localparam int LANE_W      = 10;
    localparam int DEPTH       = 4;
    localparam int MAX_CREDITS = 8;
    localparam int NB          = (ENC_W + LANE_W - 1) / LANE_W;
    localparam int CW          = $clog2(MAX_CREDITS + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              data_ready = 1'b0;
    logic              credit_return = 1'b0;
    logic [ENC_W-1:0]  encoded_flit = '0;
    logic              buffer_full;
    logic [LANE_W-1:0] lane_data;
    logic              lane_valid;
    logic              lane_sof;
    logic              lane_eof;
    logic [CW-1:0]     credits;
    logic              credit_err;
`ifdef PHY_TX_LANE_PARITY_EN
    logic              lane_par;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phy_tx_lane_manager #(
        .ENC_W       (ENC_W),
        .LANE_W      (LANE_W),
        .DEPTH       (DEPTH),
        .MAX_CREDITS (MAX_CREDITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_ready    (data_ready),
        .encoded_flit  (encoded_flit),
        .buffer_full   (buffer_full),
        .lane_data     (lane_data),
        .lane_valid    (lane_valid),
        .lane_sof      (lane_sof),
        .lane_eof      (lane_eof),
        .credit_return (credit_return),
        .credits       (credits),
`ifdef PHY_TX_LANE_PARITY_EN
        .lane_par      (lane_par),
`endif
        .credit_err    (credit_err)
    );

    // Model: flits waiting, beats still to appear on the lane (head = current), credit pool.
    typedef struct packed {
        logic [LANE_W-1:0] d;
        logic              sof;
        logic              eof;
    } beat_t;

    logic [ENC_W-1:0] m_fifo[$];
    beat_t            m_beats[$];
    int               m_cred;
    bit               m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_fifo.delete();
        m_beats.delete();
        m_cred = MAX_CREDITS;
        m_err  = 1'b0;
    endtask

    task automatic check_all();
        beat_t e;
        bit    ev;
        ev = (m_beats.size() > 0);
        e  = ev ? m_beats[0] : '0;
        chk("lane_valid",  64'(lane_valid),  64'(ev));
        chk("lane_data",   64'(lane_data),   64'(e.d));
        chk("lane_sof",    64'(lane_sof),    64'(e.sof));
        chk("lane_eof",    64'(lane_eof),    64'(e.eof));
        chk("credits",     64'(credits),     64'(m_cred));
        chk("credit_err",  64'(credit_err),  64'(m_err));
        chk("buffer_full", 64'(buffer_full), 64'(m_fifo.size() == DEPTH));
`ifdef PHY_TX_LANE_PARITY_EN
        chk("lane_par",    64'(lane_par),    64'(ev ? ^e.d : 1'b0));
`endif
    endtask

    task automatic model_step(input bit dr, input logic [ENC_W-1:0] f, input bit cr, output bit acc);
        logic [NB*LANE_W-1:0] w;
        bit load;
        acc  = dr && (m_fifo.size() < DEPTH);
        load = 1'b0;
        if (m_beats.size() > 0) void'(m_beats.pop_front());
        if (m_beats.size() == 0 && m_fifo.size() > 0 && m_cred > 0) begin
            w = '0;
            w[ENC_W-1:0] = m_fifo.pop_front();
            for (int b = 0; b < NB; b++)
                m_beats.push_back({w[b*LANE_W +: LANE_W], (b == 0), (b == NB - 1)});
            load = 1'b1;
        end
        if (cr && !load) begin
            if (m_cred == MAX_CREDITS) m_err = 1'b1;
            else                       m_cred++;
        end else if (load && !cr) begin
            m_cred--;
        end
        if (acc) m_fifo.push_back(f);
    endtask

    task automatic step(input bit dr, input logic [ENC_W-1:0] f, input bit cr, output bit acc);
        data_ready    = dr;
        encoded_flit  = f;
        credit_return = cr;
        model_step(dr, f, cr, acc);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, acc);
    endtask

    task automatic push_flits(input int n);
        int sent;
        int guard;
        bit acc;
        logic [ENC_W-1:0] f;
        sent  = 0;
        guard = 0;
        f = ENC_W'({$urandom(), $urandom()});
        while (sent < n && guard < 200) begin
            step(1'b1, f, 1'b0, acc);
            if (acc) begin
                sent++;
                f = ENC_W'({$urandom(), $urandom()});
            end
            guard++;
        end
        chk("push_timeout", 64'(sent), 64'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_ready = 1'b0;
        credit_return = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        m_reset();
        @(negedge clk);
        do_reset();

        // Single flit
        step(1'b1, 50'h1_2345_6789_ABCD, 1'b0, acc);
        step(1'b0, '0, 1'b0, acc);
        chk("single_sof",  64'(lane_sof),  64'(1));
        chk("single_data", 64'(lane_data), 64'(10'h3CD));
        idle(6);
        chk("single_credits", 64'(credits), 64'(7));

        // Back-to-back
        do_reset();
        push_flits(3);
        idle(20);
        chk("b2b_credits", 64'(credits), 64'(5));

        // Credit exhaustion, then restart on one credit
        do_reset();
        push_flits(10);
        idle(60);
        chk("exhaust_credits", 64'(credits),    64'(0));
        chk("exhaust_valid",   64'(lane_valid), 64'(0));
        step(1'b0, '0, 1'b1, acc);
        step(1'b0, '0, 1'b0, acc);
        chk("restart_sof", 64'(lane_sof), 64'(1));
        idle(10);

        // Backpressure at zero credits
        push_flits(3);
        chk("bp_full", 64'(buffer_full), 64'(1));
        step(1'b1, 50'h2_AAAA_5555_0F0F, 1'b0, acc);
        chk("bp_held", 64'(acc), 64'(0));
        step(1'b1, 50'h2_AAAA_5555_0F0F, 1'b1, acc);
        push_flits(1);
        idle(40);

        // Credit overflow and return coinciding with a load
        do_reset();
        step(1'b0, '0, 1'b1, acc);
        chk("ovf_credits", 64'(credits),    64'(8));
        chk("ovf_err",     64'(credit_err), 64'(1));
        idle(3);
        step(1'b1, ENC_W'({$urandom(), $urandom()}), 1'b0, acc);
        step(1'b0, '0, 1'b1, acc);
        chk("coincide_credits", 64'(credits), 64'(8));
        idle(8);

        // Reset mid-flit
        do_reset();
        push_flits(3);
        idle(3);
        rst = 1'b1;
        #1;
        chk("rst_valid",   64'(lane_valid),  64'(0));
        chk("rst_data",    64'(lane_data),   64'(0));
        chk("rst_credits", 64'(credits),     64'(8));
        chk("rst_full",    64'(buffer_full), 64'(0));
        @(negedge clk);
        m_reset();
        check_all();
        rst = 1'b0;
        idle(10);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(bit'($urandom_range(0, 1)), ENC_W'({$urandom(), $urandom()}),
                 ($urandom_range(0, 3) == 0), acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
